spi_target: RTL and testbench
=============================

// Module: spi_target
// PURPOSE
//  SPI mode-0 (CPOL=0, CPHA=0), MSB-first, 8-bit target: responder side of the housekeeping SPI master.
//  Oversamples sck/mosi/csb in the clk_i domain, then delivers received bytes as 1-cycle pulses.
//  Returns bytes from a 1-entry tx buffer filled by a valid/ready handshake.
//  Sits between the housekeeping pads and the register-access logic.
// PARAMETERS
//  SYNC_STAGES  2      flops per input synchronizer (>=2)
//  TX_IDLE      8'hFF  byte shifted out when the tx buffer is empty at load time
// PORTS
//  clk_i          in   1  system clock
//  reset_ni       in   1  asynchronous active-low reset
//  spi_sck_i      in   1  SPI clock from initiator
//  spi_csb_i      in   1  chip select, active low
//  spi_mosi_i     in   1  initiator -> target data
//  spi_miso_o     out  1  target -> initiator data
//  spi_miso_oe_o  out  1  miso pad output enable; high while selected
//  rx_data_o      out  8  last complete received byte; holds its value until the next byte completes
//  rx_valid_o     out  1  1-cycle pulse: rx_data_o updated
//  tx_data_i      in   8  next byte to return
//  tx_valid_i     in   1  tx_data_i valid
//  tx_ready_o     out  1  tx buffer empty (transfer when valid & ready)
//  tx_underrun_o  out  1  1-cycle pulse: TX_IDLE loaded because the buffer was empty
//  busy_o         out  1  selected (state ACTIVE)
// BEHAVIOUR
//  Reset values: miso 0, miso_oe 0, rx_data 8'h00, rx_valid 0, tx_ready 1, underrun 0, busy 0.
//    Synchronizer reset values: sck 0, csb 1, mosi 0. Reset is async: outputs take reset values immediately, mid-byte included.
//  Edge detect: rise = sck_s & ~sck_q, fall = ~sck_s & sck_q. sel_fall and sel_rise are detected the same way from csb_s.
//  States IDLE/ACTIVE:
//    IDLE -> ACTIVE on csb falling edge. In that cycle: bit_cnt<=0, load shift_out, miso<=shift_out[7].
//    ACTIVE -> IDLE on csb rising edge. Partial byte is discarded, no rx_valid, bit_cnt<=0, miso_oe<=0.
//      The tx buffer is not touched by an abort.
//    sck edges seen in IDLE are ignored.
//  Rise (ACTIVE): shift_in <= {shift_in[6:0],mosi_s}; bit_cnt++ (3-bit, wraps 7->0).
//    When bit_cnt==7: rx_data_o <= {shift_in[6:0],mosi_s} and rx_valid_o=1 on the next cycle.
//  Fall (ACTIVE), bit_cnt!=0: miso <= shift_out[6]; shift_out <<= 1.
//  Fall (ACTIVE), bit_cnt==0 (byte boundary): load shift_out and drive its bit7. Back-to-back bytes need no csb toggle.
//  Load: if buffer full, take tx buffer and clear it. Else take TX_IDLE and pulse tx_underrun_o.
//  Load with tx_valid_i in the same cycle, buffer empty: load sees empty (sends TX_IDLE); the new byte is stored. No bypass.
//  tx_ready_o = ~tx_full. While full, tx_valid_i is ignored.
//  No rx backpressure: the consumer must accept every rx_valid pulse.
//  Latency: rx_valid rises <= SYNC_STAGES+2 clk after the 8th sck rise at the pin. miso updates <= SYNC_STAGES+2 clk after sck fall.
//  Timing requirements:
//    sck high and low each >= SYNC_STAGES+3 clk (housekeeping master gives 8).
//    csb low >= SYNC_STAGES+3 clk before the first sck rise.
//  Simultaneous csb rise and sck edge in one cycle: csb wins, edge ignored.
// STRUCTURE
//  spi_pkg: spi_target_state_t {IDLE, ACTIVE}, SPI_BYTE_W=8, SPI_TX_IDLE default.
//  Sub-module bit_sync (N-stage sync, parameterized reset value), instantiated for sck, csb, mosi.
//  FSM, counters and shift registers live in spi_target.
// TESTING (bench drives pins with a model of the housekeeping master, sck = clk/16, plus a csb driver)
//  1. Reset, no stimulus -> miso_o 0, miso_oe 0, rx_valid 0, tx_ready 1, busy 0.
//  2. Preload tx 8'hA5; csb low; initiator sends 8'h3C -> rx_data 8'h3C with exactly one rx_valid pulse;
//     initiator reads 8'hA5; tx_ready back to 1.
//  3. One frame, two bytes: tx 8'h12 preloaded, 8'h34 pushed after the first load; mosi 8'hF0, 8'h0F
//     -> rx pulses 8'hF0 then 8'h0F; miso returns 8'h12, 8'h34; no underrun.
//  4. Empty tx buffer; send 8'h55 -> initiator reads 8'hFF, one tx_underrun pulse, rx_data 8'h55.
//  5. csb high after 4 sck rises -> no rx_valid, miso_oe 0; next frame 8'h81 -> rx_data 8'h81.
//  6. reset_ni low mid-byte (after 3 rises) -> outputs at reset values without a clk edge; after release, a clean 8'hC3 is received.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI target.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W = 8;
  localparam logic [SPI_BYTE_W-1:0] SPI_TX_IDLE = 8'hFF;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_target_state_t;

endpackage

// File: rtl/bit_sync.sv
// N-stage single-bit synchronizer with a selectable reset value.
//  clk_i    in  clock of the destination domain
//  reset_ni in  asynchronous active-low reset
//  d_i      in  asynchronous input
//  q_o      out synchronized output
module bit_sync #(
  parameter int unsigned N       = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) sync_q <= {N{RST_VAL}};
    else           sync_q <= {sync_q[N-2:0], d_i};
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0, MSB-first, 8-bit target with oversampled pins and a 1-entry tx buffer.
//  clk_i/reset_ni              system clock, async active-low reset
//  spi_sck_i/csb_i/mosi_i      pins from the initiator
//  spi_miso_o/spi_miso_oe_o    data and pad enable back to the initiator
//  rx_data_o/rx_valid_o        received byte, 1-cycle update pulse
//  tx_data_i/valid_i/ready_o   tx buffer fill handshake
//  tx_underrun_o               pulse when TX_IDLE was loaded from an empty buffer
//  busy_o                      selected
module spi_target
  import spi_pkg::*;
#(
  parameter int unsigned            SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0]  TX_IDLE     = SPI_TX_IDLE
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  spi_sck_i,
  input  logic                  spi_csb_i,
  input  logic                  spi_mosi_i,
  output logic                  spi_miso_o,
  output logic                  spi_miso_oe_o,
  output logic [SPI_BYTE_W-1:0] rx_data_o,
  output logic                  rx_valid_o,
  input  logic [SPI_BYTE_W-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  tx_underrun_o,
  output logic                  busy_o
);

  localparam int unsigned CNT_W = 3;

  logic sck_s, csb_s, mosi_s;
  logic sck_q, csb_q;
  logic rise, fall, sel_rise, sel_fall;

  spi_target_state_t state_q, state_d;

  logic [CNT_W-1:0]      bit_cnt_q;
  logic [SPI_BYTE_W-1:0] shift_in_q, shift_out_q, tx_buf_q;
  logic                  tx_full_q;

  logic                  start_c, stop_c, sample_c, shift_c, load_c;
  logic [SPI_BYTE_W-1:0] load_byte_c, rx_next_c;

  bit_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sck (
    .clk_i(clk_i), .reset_ni(reset_ni), .d_i(spi_sck_i), .q_o(sck_s));
  bit_sync #(.N(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_csb (
    .clk_i(clk_i), .reset_ni(reset_ni), .d_i(spi_csb_i), .q_o(csb_s));
  bit_sync #(.N(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk_i), .reset_ni(reset_ni), .d_i(spi_mosi_i), .q_o(mosi_s));

  // Delayed copies for edge detection.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sck_q <= 1'b0;
      csb_q <= 1'b1;
    end else begin
      sck_q <= sck_s;
      csb_q <= csb_s;
    end
  end

  assign rise     =  sck_s & ~sck_q;
  assign fall     = ~sck_s &  sck_q;
  assign sel_rise =  csb_s & ~csb_q;
  assign sel_fall = ~csb_s &  csb_q;

  // State register.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) state_q <= IDLE;
    else           state_q <= state_d;
  end

  // Next state and datapath strobes; a deselect outranks any sck edge in the same cycle.
  always_comb begin
    state_d  = state_q;
    start_c  = 1'b0;
    stop_c   = 1'b0;
    sample_c = 1'b0;
    shift_c  = 1'b0;
    load_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_fall) begin
          state_d = ACTIVE;
          start_c = 1'b1;
          load_c  = 1'b1;
        end
      end
      ACTIVE: begin
        if (sel_rise) begin
          state_d = IDLE;
          stop_c  = 1'b1;
        end else if (rise) begin
          sample_c = 1'b1;
        end else if (fall) begin
          if (bit_cnt_q == '0) load_c  = 1'b1;
          else                 shift_c = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign load_byte_c = tx_full_q ? tx_buf_q : TX_IDLE;
  assign rx_next_c   = {shift_in_q[SPI_BYTE_W-2:0], mosi_s};

  // Shift registers, bit counter and registered outputs.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      bit_cnt_q     <= '0;
      shift_in_q    <= '0;
      shift_out_q   <= '0;
      spi_miso_o    <= 1'b0;
      rx_data_o     <= '0;
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
    end else begin
      rx_valid_o    <= 1'b0;
      tx_underrun_o <= 1'b0;
      if (start_c || stop_c) bit_cnt_q <= '0;
      if (stop_c) spi_miso_o <= 1'b0;
      if (sample_c) begin
        shift_in_q <= rx_next_c;
        bit_cnt_q  <= CNT_W'(bit_cnt_q + CNT_W'(1));
        if (bit_cnt_q == CNT_W'(SPI_BYTE_W - 1)) begin
          rx_data_o  <= rx_next_c;
          rx_valid_o <= 1'b1;
        end
      end
      if (shift_c) begin
        spi_miso_o  <= shift_out_q[SPI_BYTE_W-2];
        shift_out_q <= {shift_out_q[SPI_BYTE_W-2:0], 1'b0};
      end
      if (load_c) begin
        shift_out_q   <= load_byte_c;
        spi_miso_o    <= load_byte_c[SPI_BYTE_W-1];
        tx_underrun_o <= ~tx_full_q;
      end
    end
  end

  // 1-entry tx buffer; a load sees the buffer state from before any same-cycle push.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      tx_buf_q  <= '0;
      tx_full_q <= 1'b0;
    end else if (tx_full_q) begin
      if (load_c) tx_full_q <= 1'b0;
    end else if (tx_valid_i) begin
      tx_buf_q  <= tx_data_i;
      tx_full_q <= 1'b1;
    end
  end

  assign tx_ready_o    = ~tx_full_q;
  assign busy_o        = (state_q == ACTIVE);
  assign spi_miso_oe_o = (state_q == ACTIVE);

endmodule

// File: tb/tb_spi_target.sv
// Directed bench for spi_target: a housekeeping-master model (sck = clk/16) plus table-driven frames.
module tb_spi_target;

  logic       clk = 1'b0;
  logic       reset_ni = 1'b0;
  logic       sck = 1'b0, csb = 1'b1, mosi = 1'b0;
  logic       miso, miso_oe, rx_valid, tx_ready, underrun, busy;
  logic [7:0] rx_data;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;

  int errors = 0;
  int checks = 0;
  int rx_cnt = 0;
  int uf_cnt = 0;
  logic [7:0] rx_hist [$];

  always #5 clk = ~clk;

  spi_target dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .spi_sck_i(sck), .spi_csb_i(csb), .spi_mosi_i(mosi),
    .spi_miso_o(miso), .spi_miso_oe_o(miso_oe),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid),
    .tx_data_i(tx_data), .tx_valid_i(tx_valid), .tx_ready_o(tx_ready),
    .tx_underrun_o(underrun), .busy_o(busy)
  );

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rx_cnt++;
      rx_hist.push_back(rx_data);
    end
    if (underrun === 1'b1) uf_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    wait_clk(1);
    tx_valid = 1'b0;
  endtask

  task automatic sel_low();
    csb = 1'b0;
    wait_clk(8);
  endtask

  // One byte, MSB first; the last byte of a frame drops sck and raises csb together.
  task automatic send_byte(input logic [7:0] b, input bit last, output logic [7:0] r);
    for (int i = 7; i >= 0; i--) begin
      mosi = b[i];
      wait_clk(8);
      r[i] = miso;
      sck  = 1'b1;
      wait_clk(8);
      sck = 1'b0;
      if (last && i == 0) csb = 1'b1;
    end
    wait_clk(8);
  endtask

  typedef struct {
    bit         pre;
    logic [7:0] tx;
    logic [7:0] mosi_b;
    logic [7:0] exp_miso;
    int         exp_uf;
  } vec_t;

  vec_t vecs [5];

  initial begin
    logic [7:0] r0, r1;
    int rx0, uf0;

    vecs[0] = '{1'b1, 8'hA5, 8'h3C, 8'hA5, 0};
    vecs[1] = '{1'b0, 8'h00, 8'h55, 8'hFF, 1};
    vecs[2] = '{1'b1, 8'h00, 8'hFF, 8'h00, 0};
    vecs[3] = '{1'b1, 8'hFF, 8'h00, 8'hFF, 0};
    vecs[4] = '{1'b1, 8'h6E, 8'h96, 8'h6E, 0};

    // Reset state.
    wait_clk(3);
    check("rst_miso", 32'(miso), 32'd0);
    check("rst_oe", 32'(miso_oe), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'h00);
    reset_ni = 1'b1;
    wait_clk(8);

    // Single-byte frames from the table.
    foreach (vecs[k]) begin
      rx0 = rx_cnt;
      uf0 = uf_cnt;
      if (vecs[k].pre) begin
        push_tx(vecs[k].tx);
        check($sformatf("v%0d_ready_full", k), 32'(tx_ready), 32'd0);
      end
      sel_low();
      check($sformatf("v%0d_busy", k), 32'(busy), 32'd1);
      check($sformatf("v%0d_oe", k), 32'(miso_oe), 32'd1);
      send_byte(vecs[k].mosi_b, 1'b1, r0);
      check($sformatf("v%0d_rx_cnt", k), 32'(rx_cnt - rx0), 32'd1);
      check($sformatf("v%0d_rx_data", k), 32'(rx_data), 32'(vecs[k].mosi_b));
      check($sformatf("v%0d_miso", k), 32'(r0), 32'(vecs[k].exp_miso));
      check($sformatf("v%0d_underrun", k), 32'(uf_cnt - uf0), 32'(vecs[k].exp_uf));
      check($sformatf("v%0d_ready", k), 32'(tx_ready), 32'd1);
      check($sformatf("v%0d_idle", k), 32'({busy, miso_oe}), 32'd0);
    end

    // Two bytes in one frame, second tx byte pushed after the first load.
    rx0 = rx_cnt;
    uf0 = uf_cnt;
    rx_hist.delete();
    push_tx(8'h12);
    sel_low();
    check("b2b_ready_after_load", 32'(tx_ready), 32'd1);
    push_tx(8'h34);
    check("b2b_ready_full", 32'(tx_ready), 32'd0);
    send_byte(8'hF0, 1'b0, r0);
    send_byte(8'h0F, 1'b1, r1);
    check("b2b_rx_cnt", 32'(rx_cnt - rx0), 32'd2);
    if (rx_hist.size() == 2) begin
      check("b2b_rx0", 32'(rx_hist[0]), 32'hF0);
      check("b2b_rx1", 32'(rx_hist[1]), 32'h0F);
    end
    check("b2b_miso0", 32'(r0), 32'h12);
    check("b2b_miso1", 32'(r1), 32'h34);
    check("b2b_underrun", 32'(uf_cnt - uf0), 32'd0);

    // Abort after 4 rises, then a clean frame.
    rx0 = rx_cnt;
    sel_low();
    for (int i = 0; i < 4; i++) begin
      mosi = 1'b1;
      wait_clk(8);
      sck = 1'b1;
      wait_clk(8);
      sck = 1'b0;
    end
    wait_clk(8);
    csb = 1'b1;
    wait_clk(10);
    check("abort_rx_cnt", 32'(rx_cnt - rx0), 32'd0);
    check("abort_oe", 32'(miso_oe), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    sel_low();
    send_byte(8'h81, 1'b1, r0);
    check("abort_next_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
    check("abort_next_rx", 32'(rx_data), 32'h81);

    // Asynchronous reset mid-byte, then a clean frame.
    push_tx(8'h77);
    sel_low();
    for (int i = 0; i < 3; i++) begin
      mosi = 1'b0;
      wait_clk(8);
      sck = 1'b1;
      wait_clk(8);
      if (i < 2) sck = 1'b0;
    end
    #2 reset_ni = 1'b0;
    #1;
    check("arst_miso", 32'(miso), 32'd0);
    check("arst_oe", 32'(miso_oe), 32'd0);
    check("arst_rx_data", 32'(rx_data), 32'h00);
    check("arst_rx_valid", 32'(rx_valid), 32'd0);
    check("arst_tx_ready", 32'(tx_ready), 32'd1);
    check("arst_underrun", 32'(underrun), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    wait_clk(1);
    sck  = 1'b0;
    csb  = 1'b1;
    mosi = 1'b0;
    wait_clk(4);
    reset_ni = 1'b1;
    wait_clk(8);
    rx0 = rx_cnt;
    sel_low();
    send_byte(8'hC3, 1'b1, r0);
    check("arst_next_rx_cnt", 32'(rx_cnt - rx0), 32'd1);
    check("arst_next_rx", 32'(rx_data), 32'hC3);
    check("arst_next_miso", 32'(r0), 32'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Hard stop in case a stimulus task stalls.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1);
  end

endmodule
